foc_mul_pipe: RTL and testbench
===============================

# foc_mul_pipe

Parametrised, pipelined multiplier with valid/ready flow control, tag sideband, and an output stage for round-half-up, right shift and saturation. It replaces the fixed-width, free-running DSP multipliers in the FOC datapath (Park/Clarke, PI gains). It adds backpressure, per-operand signedness, Q-format rescaling and a sticky overflow flag. The block maps onto one DSP48 per instance.

## Interface
Parameters:
- A_WIDTH, 15, width of operand a
- B_WIDTH, 15, width of operand b
- A_SIGNED, 0, 1 = a is two's complement, 0 = unsigned
- B_SIGNED, 1, same for b
- NUM_STAGE, 4, register stages; legal range 3..6
- OUT_WIDTH, 30, result width
- SHIFT, 0, arithmetic right shift applied to the product; 0..A_WIDTH+B_WIDTH-1
- TAG_WIDTH, 4, sideband width; minimum 1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  A_WIDTH  operand a
- in_b  in  B_WIDTH  operand b
- in_tag  in  TAG_WIDTH  opaque tag, carried with the beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_p  out  OUT_WIDTH  rounded, shifted, saturated product
- out_tag  out  TAG_WIDTH  tag of the beat on out_p
- out_sat  out  1  the current out_p beat was clipped (qualified by out_valid)
- sat_sticky  out  1  set by any delivered clipped beat; cleared by sat_clr
- sat_clr  in  1  synchronous clear of sat_sticky

## Operation
- Define P = A_WIDTH+B_WIDTH and RS = A_SIGNED|B_SIGNED. The result is signed when RS = 1, unsigned otherwise.
- Each operand is sign- or zero-extended to P+1 bits according to its flag. The full product is exact in P bits.
- Rounding (SHIFT>0): add 2^(SHIFT-1), then shift right arithmetically by SHIFT. Ties round toward +inf. With SHIFT=0 the product passes through unchanged.
- Saturation: if the shifted value lies outside the OUT_WIDTH range, clamp it to max or min and set out_sat. The range is signed when RS = 1, unsigned when RS = 0. If OUT_WIDTH ≥ P−SHIFT+1, clipping can never occur.
- Pipeline stages:
  - stage 1 registers a, b and tag;
  - stages 2..NUM_STAGE−1 hold the product (retiming into the DSP M/P registers);
  - stage NUM_STAGE registers the round/shift/saturate result, out_sat and the tag.
- Each stage has a valid bit.
- Global advance: ce = out_ready | ~out_valid. All stages, bubbles included, move only when ce = 1. No stage advances when ce = 0.
- in_ready = ce. This is a combinational path from out_ready, and it is documented as such for integrators.
- A beat is accepted when in_valid & in_ready, and delivered when out_valid & out_ready.
- sat_sticky sets on a delivered beat with out_sat = 1. If sat_clr and a set event occur in the same cycle, the set wins.
- Reset (asynchronous assert, any cycle, including mid-stream): all valid bits, data registers, out_p, out_tag, out_sat and sat_sticky go to 0. Beats in flight are discarded. in_ready = 1 as soon as reset deasserts.

## Timing
- Latency: a beat accepted at edge E appears on out_p/out_valid after edge E+NUM_STAGE−1, provided out_ready stayed high.
- Throughput: one beat per cycle with no bubbles while out_ready = 1.
- Stall: while out_valid = 1 and out_ready = 0, every register holds. out_p, out_tag and out_sat stay stable. in_ready = 0.
- Stalls preserve order. No beat is lost or duplicated.
- sat_sticky updates on the edge that completes the delivery.

## Structure
- Package foc_mul_pkg holds:
  - localparam functions for P, the extended width and the OUT_WIDTH min/max constants for signed and unsigned results;
  - the saturate function.
- One sub-module, foc_mul_round_sat: a registered shift/round/clip stage (the final stage) with its valid and tag.
- The multiply stages stay inline so the DSP48 inference is not disturbed.

## Test plan
- Default parameters, a=16384, b=−8192 → out_p=−134217728 after exactly 3 cycles, out_sat=0. Stream 8 beats back-to-back → 8 consecutive out_valid cycles with tags in order.
- OUT_WIDTH=16, SHIFT=14, rounding cases:
  - a=1, b=8192 → 1;
  - a=1, b=8191 → 0;
  - a=1, b=−8192 → 0;
  - a=3, b=2731 → 1.
- Same config, a=32767, b=−32768 → out_p=−32768, out_sat=1, sat_sticky=1. Then a=32767, b=16383 → out_p=32765, out_sat=0, sat_sticky still 1. Pulse sat_clr → sat_sticky=0. sat_clr in the same cycle as a clipped delivery → sat_sticky stays 1.
- Backpressure: stream tags 0..5 with out_ready low for 3 cycles once the first result appears. Required: out_p held stable, in_ready=0 during the stall, all 6 tags delivered once and in order.
- Reset mid-stream with 3 beats in flight → all outputs 0 at once. After release, no stale beat appears, and a new beat returns after NUM_STAGE−1 cycles.
- A_SIGNED=B_SIGNED=0, OUT_WIDTH=8, SHIFT=0, a=20, b=20 → out_p=255, out_sat=1.

Source files
------------

// File: rtl/foc_mul_pkg.sv
// foc_mul_pkg: shared width helpers, output range limits and saturation logic
package foc_mul_pkg;

    // Widest intermediate used for rounding, shifting and range comparison
    localparam int unsigned MAX_W = 96;
    localparam logic [MAX_W-1:0] ONE = MAX_W'(1);

    function automatic int unsigned prod_width(input int unsigned aw, input int unsigned bw);
        return aw + bw;
    endfunction

    // Operands are extended one bit beyond the product so mixed signedness multiplies exactly
    function automatic int unsigned ext_width(input int unsigned aw, input int unsigned bw);
        return prod_width(aw, bw) + 1;
    endfunction

    function automatic logic signed [MAX_W-1:0] out_max(input int unsigned ow, input bit rs);
        return rs ? signed'((ONE << (ow - 1)) - ONE) : signed'((ONE << ow) - ONE);
    endfunction

    function automatic logic signed [MAX_W-1:0] out_min(input int unsigned ow, input bit rs);
        return rs ? signed'(-(ONE << (ow - 1))) : '0;
    endfunction

    function automatic logic clipped(input logic signed [MAX_W-1:0] v,
                                     input int unsigned ow, input bit rs);
        return (v > out_max(ow, rs)) || (v < out_min(ow, rs));
    endfunction

    function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W-1:0] v,
                                                         input int unsigned ow, input bit rs);
        if (v > out_max(ow, rs)) return out_max(ow, rs);
        if (v < out_min(ow, rs)) return out_min(ow, rs);
        return v;
    endfunction

endpackage

// File: rtl/foc_mul_round_sat.sv
// foc_mul_round_sat: final pipeline stage - round half up, arithmetic shift, clamp
module foc_mul_round_sat
    import foc_mul_pkg::*;
#(
    parameter int unsigned EXT_W     = 31,
    parameter int unsigned OUT_WIDTH = 30,
    parameter int unsigned SHIFT     = 0,
    parameter bit          RS        = 1'b1,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic signed [EXT_W-1:0] in_prod,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    output logic [OUT_WIDTH-1:0]    out_p,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    out_sat
);

    logic signed [MAX_W-1:0] wide;
    logic signed [MAX_W-1:0] rounded;
    logic signed [MAX_W-1:0] shifted;

    // Sign-extend, add half an LSB of the shifted result (zero when SHIFT = 0), then shift
    always_comb begin
        wide    = {{(MAX_W-EXT_W){in_prod[EXT_W-1]}}, in_prod};
        rounded = wide + ((ONE << SHIFT) >> 1);
        shifted = rounded >>> SHIFT;
    end

    // Output register; bubbles move through too, out_valid qualifies the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            out_valid <= in_valid;
            out_p     <= OUT_WIDTH'(saturate(shifted, OUT_WIDTH, RS));
            out_tag   <= in_tag;
            out_sat   <= clipped(shifted, OUT_WIDTH, RS);
        end
    end

endmodule

// File: rtl/foc_mul_pipe.sv
// foc_mul_pipe: pipelined multiplier with valid/ready, tag sideband and output rescaling
module foc_mul_pipe
    import foc_mul_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 15,
    parameter int unsigned B_WIDTH   = 15,
    parameter int unsigned A_SIGNED  = 0,
    parameter int unsigned B_SIGNED  = 1,
    parameter int unsigned NUM_STAGE = 4,
    parameter int unsigned OUT_WIDTH = 30,
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_p,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_sat,
    output logic                 sat_sticky,
    input  logic                 sat_clr
);

    localparam int unsigned EXT_W = ext_width(A_WIDTH, B_WIDTH);
    localparam bit          RS    = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam int unsigned NPROD = NUM_STAGE - 2;

    logic                    ce;
    logic                    v1;
    logic [A_WIDTH-1:0]      a_q;
    logic [B_WIDTH-1:0]      b_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic signed [EXT_W-1:0] a_ext;
    logic signed [EXT_W-1:0] b_ext;
    logic signed [EXT_W-1:0] mult;
    logic                    pv     [NPROD];
    logic signed [EXT_W-1:0] prod_q [NPROD];
    logic [TAG_WIDTH-1:0]    ptag   [NPROD];

    // Single global advance: in_ready is combinational from out_ready
    assign ce       = out_ready | ~out_valid;
    assign in_ready = ce;

    assign a_ext = {{(EXT_W-A_WIDTH){(A_SIGNED != 0) && a_q[A_WIDTH-1]}}, a_q};
    assign b_ext = {{(EXT_W-B_WIDTH){(B_SIGNED != 0) && b_q[B_WIDTH-1]}}, b_q};
    assign mult  = a_ext * b_ext;

    // Stage 1: operand and tag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else if (ce) begin
            v1    <= in_valid;
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
        end
    end

    // Stages 2..NUM_STAGE-1: product delay line, left plain so it retimes into the DSP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NPROD; i++) begin
                pv[i]     <= 1'b0;
                prod_q[i] <= '0;
                ptag[i]   <= '0;
            end
        end else if (ce) begin
            pv[0]     <= v1;
            prod_q[0] <= mult;
            ptag[0]   <= tag_q;
            for (int unsigned i = 1; i < NPROD; i++) begin
                pv[i]     <= pv[i-1];
                prod_q[i] <= prod_q[i-1];
                ptag[i]   <= ptag[i-1];
            end
        end
    end

    foc_mul_round_sat #(
        .EXT_W     (EXT_W),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT),
        .RS        (RS),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_round_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .in_valid  (pv[NPROD-1]),
        .in_prod   (prod_q[NPROD-1]),
        .in_tag    (ptag[NPROD-1]),
        .out_valid (out_valid),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .out_sat   (out_sat)
    );

    // Sticky overflow: a delivered clipped beat sets it and takes priority over sat_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_sat) begin
            sat_sticky <= 1'b1;
        end else if (sat_clr) begin
            sat_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_foc_mul_pipe.sv
// tb_foc_mul_pipe: three lock-stepped configurations checked against an arithmetic model
module tb_foc_mul_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_tag;
    logic        out_ready;
    logic        sat_clr;

    logic        v0, v1, v2, r0, r1, r2, s0, s1, s2, k0, k1, k2;
    logic [29:0] p0;
    logic [15:0] p1;
    logic [7:0]  p2;
    logic [3:0]  t0, t1, t2;

    foc_mul_pipe u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0),
        .in_a(in_a[14:0]), .in_b(in_b[14:0]), .in_tag(in_tag),
        .out_valid(v0), .out_ready(out_ready), .out_p(p0), .out_tag(t0),
        .out_sat(s0), .sat_sticky(k0), .sat_clr(sat_clr)
    );

    foc_mul_pipe #(.A_WIDTH(16), .B_WIDTH(16), .OUT_WIDTH(16), .SHIFT(14)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(v1), .out_ready(out_ready), .out_p(p1), .out_tag(t1),
        .out_sat(s1), .sat_sticky(k1), .sat_clr(sat_clr)
    );

    foc_mul_pipe #(.A_SIGNED(0), .B_SIGNED(0), .OUT_WIDTH(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2),
        .in_a(in_a[14:0]), .in_b(in_b[14:0]), .in_tag(in_tag),
        .out_valid(v2), .out_ready(out_ready), .out_p(p2), .out_tag(t2),
        .out_sat(s2), .sat_sticky(k2), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    logic [2:0]  ov, ir, osat, stk;
    logic [63:0] op [3];
    logic [3:0]  ot [3];
    assign ov   = {v2, v1, v0};
    assign ir   = {r2, r1, r0};
    assign osat = {s2, s1, s0};
    assign stk  = {k2, k1, k0};
    assign op[0] = 64'(p0);
    assign op[1] = 64'(p1);
    assign op[2] = 64'(p2);
    assign ot[0] = t0;
    assign ot[1] = t1;
    assign ot[2] = t2;

    // configuration table of the three instances
    int AW [3] = '{15, 16, 15};
    int BW [3] = '{15, 16, 15};
    int AS [3] = '{0, 0, 0};
    int BS [3] = '{1, 1, 0};
    int SH [3] = '{0, 14, 0};
    int OW [3] = '{30, 16, 8};

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        int          kd;
        longint      kp;
        bit          ks;
        int          acc_step;
    } beat_t;

    beat_t  q[$];
    bit     sticky_m [3];
    int     total = 0, passed = 0, errors = 0;
    int     stepno = 0, delivered = 0, stall_budget = 0;
    bit     chk_lat = 0;
    int     next_kd = 0;
    longint next_kp = 0;
    bit     next_ks = 0;

    task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tg, obs, exp);
        end
    endtask

    // Operand value from its raw bits, exact product, round half up, floor shift, clamp
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input int d,
                                  output longint p, output bit sat);
        longint av, bv, prod, mx, mn;
        av = longint'(a) & ((longint'(1) << AW[d]) - 1);
        bv = longint'(b) & ((longint'(1) << BW[d]) - 1);
        if (AS[d] != 0 && av >= (longint'(1) << (AW[d] - 1))) av -= longint'(1) << AW[d];
        if (BS[d] != 0 && bv >= (longint'(1) << (BW[d] - 1))) bv -= longint'(1) << BW[d];
        prod = av * bv;
        if (SH[d] > 0) prod = prod + (longint'(1) << (SH[d] - 1));
        prod = prod >>> SH[d];
        if (AS[d] != 0 || BS[d] != 0) begin
            mx = (longint'(1) << (OW[d] - 1)) - 1;
            mn = -(longint'(1) << (OW[d] - 1));
        end else begin
            mx = (longint'(1) << OW[d]) - 1;
            mn = 0;
        end
        sat = (prod > mx) || (prod < mn);
        p   = (prod > mx) ? mx : ((prod < mn) ? mn : prod);
    endfunction

    function automatic logic [63:0] mask_to(input longint p, input int w);
        return 64'(p) & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input bit ordy, input bit clr, output bit acc);
        beat_t  bt;
        longint p;
        bit     s;
        bit     dlv;
        @(negedge clk);
        if (stall_budget > 0 && ov[0]) begin
            ordy = 1'b0;
            stall_budget--;
        end
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        sat_clr   = clr;
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("sticky_d%0d", d), 64'(stk[d]), 64'(sticky_m[d]));
        if (ov[0] && q.size() == 0)
            chk("spurious_valid", 64'(ov[0]), 64'd0);
        if (ov[0] && !ordy) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("stall_in_ready_d%0d", d), 64'(ir[d]), 64'd0);
                if (q.size() > 0) begin
                    model(q[0].a, q[0].b, d, p, s);
                    chk($sformatf("stall_hold_p_d%0d", d), op[d], mask_to(p, OW[d]));
                end
            end
        end
        dlv = ov[0] && ordy && (q.size() > 0);
        if (dlv) begin
            bt = q.pop_front();
            delivered++;
            if (chk_lat)
                chk("latency", 64'(stepno - bt.acc_step - 1), 64'd3);
            for (int d = 0; d < 3; d++) begin
                model(bt.a, bt.b, d, p, s);
                chk($sformatf("valid_d%0d", d), 64'(ov[d]), 64'd1);
                chk($sformatf("p_d%0d", d), op[d], mask_to(p, OW[d]));
                chk($sformatf("sat_d%0d", d), 64'(osat[d]), 64'(s));
                chk($sformatf("tag_d%0d", d), 64'(ot[d]), 64'(bt.tag));
                if (bt.kd == d + 1) begin
                    chk($sformatf("const_p_d%0d", d), op[d], mask_to(bt.kp, OW[d]));
                    chk($sformatf("const_sat_d%0d", d), 64'(osat[d]), 64'(bt.ks));
                end
                sticky_m[d] = s ? 1'b1 : (clr ? 1'b0 : sticky_m[d]);
            end
        end else begin
            for (int d = 0; d < 3; d++)
                sticky_m[d] = clr ? 1'b0 : sticky_m[d];
        end
        acc = v && ir[0];
        if (acc) begin
            bt = '{a: a, b: b, tag: tag, kd: next_kd, kp: next_kp, ks: next_ks, acc_step: stepno};
            q.push_back(bt);
            next_kd = 0;
        end
        stepno++;
    endtask

    task automatic drain(input int maxn);
        bit acc;
        for (int n = 0; n < maxn && q.size() > 0; n++)
            step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tg);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_valid_d%0d", tg, d), 64'(ov[d]), 64'd0);
            chk($sformatf("%s_p_d%0d", tg, d), op[d], 64'd0);
            chk($sformatf("%s_tag_d%0d", tg, d), 64'(ot[d]), 64'd0);
            chk($sformatf("%s_sat_d%0d", tg, d), 64'(osat[d]), 64'd0);
            chk($sformatf("%s_sticky_d%0d", tg, d), 64'(stk[d]), 64'd0);
        end
    endtask

    int ra [6] = '{1, 1, 1, 3, 32767, 32767};
    int rb [6] = '{8192, 8191, -8192, 2731, -32768, 16383};
    int rp [6] = '{1, 0, 0, 1, -32768, 32765};
    int rsat [6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        bit acc;
        int idx;
        int dstart;
        clk = 0; rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_tag = 0;
        out_ready = 1; sat_clr = 0;
        for (int d = 0; d < 3; d++) sticky_m[d] = 0;

        // power-on reset
        #2;
        check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("rel_in_ready_d%0d", d), 64'(ir[d]), 64'd1);

        // single beat latency and value
        chk_lat = 1;
        next_kd = 1; next_kp = -134217728; next_ks = 0;
        step(1'b1, 16'd16384, 16'hE000, 4'd5, 1'b1, 1'b0, acc);
        drain(10);

        // eight back-to-back beats
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 4'(i), 1'b1, 1'b0, acc);
        drain(12);

        // Q-format rounding and saturation constants on the 16x16, SHIFT=14 instance
        for (int i = 0; i < 6; i++) begin
            next_kd = 2; next_kp = longint'(rp[i]); next_ks = rsat[i][0];
            step(1'b1, 16'(ra[i]), 16'(rb[i]), 4'(i), 1'b1, 1'b0, acc);
        end
        next_kd = 3; next_kp = 255; next_ks = 1;
        step(1'b1, 16'd20, 16'd20, 4'd9, 1'b1, 1'b0, acc);
        drain(12);
        chk_lat = 0;
        step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk("sticky_d1_after_clip", 64'(stk[1]), 64'd1);

        // sat_clr pulse clears the flag
        step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk("sticky_d1_cleared", 64'(stk[1]), 64'd0);

        // clipped delivery coinciding with sat_clr: set wins
        next_kd = 2; next_kp = -32768; next_ks = 1;
        step(1'b1, 16'd32767, 16'h8000, 4'd3, 1'b1, 1'b1, acc);
        for (int n = 0; n < 10 && q.size() > 0; n++)
            step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b1, acc);
        step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk("sticky_d1_set_wins", 64'(stk[1]), 64'd1);

        // backpressure: three stall cycles once the first result appears
        dstart = delivered;
        stall_budget = 3;
        idx = 0;
        for (int n = 0; n < 40 && (idx < 6 || q.size() > 0); n++) begin
            step(idx < 6, 16'($urandom), 16'($urandom), 4'(idx), 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_stalls_used", 64'(stall_budget), 64'd0);
        chk("bp_delivered", 64'(delivered - dstart), 64'd6);
        drain(4);

        // reset with beats in flight
        for (int i = 0; i < 6; i++)
            step(1'b1, 16'd20, 16'd20, 4'(i + 8), 1'b1, 1'b0, acc);
        #1;
        rst_n = 0;
        #1;
        check_all_zero("midrst");
        q.delete();
        for (int d = 0; d < 3; d++) sticky_m[d] = 0;
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("midrst_in_ready_d%0d", d), 64'(ir[d]), 64'd1);
        for (int n = 0; n < 8; n++)
            step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b0, acc);
        chk_lat = 1;
        step(1'b1, 16'($urandom), 16'($urandom), 4'd7, 1'b1, 1'b0, acc);
        drain(10);
        chk_lat = 0;

        // randomized traffic with random backpressure and clears
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom), 4'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, acc);
        drain(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
